// File: rtl/alu_mult_sequencer.sv
// Multi-cycle MULT/MULTU sequencer that borrows the shared ALU (add only)
// and runs a 32-step shift-and-add multiply, leaving the 64-bit product in Hi/Lo.
module alu_mult_sequencer #(
   parameter int Width = 32
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Signed,
   input  logic [Width-1:0] MultA,
   input  logic [Width-1:0] MultB,
   output logic             ALUReq,
   input  logic             ALUGrant,
   output logic [Width-1:0] SrcA,
   output logic [Width-1:0] SrcB,
   output logic [2:0]       ALUControl,
   input  logic [Width-1:0] ALUResult,
   output logic             Busy,
   output logic             Done,
   output logic [Width-1:0] Hi,
   output logic [Width-1:0] Lo
);

   localparam int CntW = $clog2(Width);
   localparam logic [CntW-1:0] LastStep = CntW'(Width - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] MUL   = 3'd1;
   localparam logic [2:0] NEGLO = 3'd2;
   localparam logic [2:0] NEGHI = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [2:0] AluAdd = 3'b010;

   logic [2:0]       state;
   logic [Width-1:0] hi;
   logic [Width-1:0] lo;
   logic [Width-1:0] m;
   logic [CntW-1:0]  cnt;
   logic             negflag;
   logic             negcarry;
   logic             carry;

   // Magnitude of an operand; 0x80000000 maps onto itself, which is still the
   // correct unsigned magnitude.
   function automatic logic [Width-1:0] absval(input logic [Width-1:0] x,
                                               input logic sgn);
      return (sgn & x[Width-1]) ? (~x + Width'(1)) : x;
   endfunction

   always_comb begin
      ALUReq     = 1'b0;
      SrcA       = '0;
      SrcB       = '0;
      ALUControl = 3'b000;
      case (state)
         MUL: begin
            ALUReq     = 1'b1;
            SrcA       = hi;
            SrcB       = lo[0] ? m : '0;
            ALUControl = AluAdd;
         end
         NEGLO: begin
            ALUReq     = 1'b1;
            SrcA       = ~lo;
            SrcB       = Width'(1);
            ALUControl = AluAdd;
         end
         NEGHI: begin
            ALUReq     = 1'b1;
            SrcA       = ~hi;
            SrcB       = {{(Width-1){1'b0}}, negcarry};
            ALUControl = AluAdd;
         end
         DONE: begin
            ALUControl = AluAdd;
         end
         default: ;
      endcase
   end

   // The ALU only returns a 32-bit sum; the carry out is recovered by wrap-around.
   assign carry = (ALUResult < SrcA);

   assign Busy = (state != IDLE);
   assign Done = (state == DONE);
   assign Hi   = hi;
   assign Lo   = lo;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state    <= IDLE;
         hi       <= '0;
         lo       <= '0;
         m        <= '0;
         cnt      <= '0;
         negflag  <= 1'b0;
         negcarry <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  m       <= absval(MultA, Signed);
                  lo      <= absval(MultB, Signed);
                  hi      <= '0;
                  cnt     <= '0;
                  negflag <= Signed & (MultA[Width-1] ^ MultB[Width-1]);
                  state   <= MUL;
               end
            end
            MUL: begin
               if (ALUGrant) begin
                  {hi, lo} <= {carry, ALUResult, lo[Width-1:1]};
                  cnt      <= cnt + CntW'(1);
                  if (cnt == LastStep) begin
                     state <= negflag ? NEGLO : DONE;
                  end
               end
            end
            // Two's-complement negation of {Hi,Lo} as two ALU passes.
            NEGLO: begin
               if (ALUGrant) begin
                  lo       <= ALUResult;
                  negcarry <= (ALUResult == '0);
                  state    <= NEGHI;
               end
            end
            NEGHI: begin
               if (ALUGrant) begin
                  hi    <= ALUResult;
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench for alu_mult_sequencer: directed vector table plus
// randomized multiplies with random ALU grant, checked against plain arithmetic.
module tb_alu_mult_sequencer;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        Start;
   logic        Signed;
   logic [31:0] MultA;
   logic [31:0] MultB;
   logic        ALUReq;
   logic        ALUGrant;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [2:0]  ALUControl;
   logic [31:0] ALUResult;
   logic        Busy;
   logic        Done;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   // The shared ALU as the datapath would present it: a combinational adder.
   assign ALUResult = SrcA + SrcB;

   alu_mult_sequencer #(.Width(32)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Signed(Signed),
      .MultA(MultA), .MultB(MultB), .ALUReq(ALUReq), .ALUGrant(ALUGrant),
      .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .ALUResult(ALUResult),
      .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [63:0] prod;
      int          steps;
      int          mode;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [63:0] refProduct(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic sgn);
      longint sa;
      longint sb;
      if (sgn) begin
         sa = $signed(a);
         sb = $signed(b);
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   function automatic int refSteps(input logic [31:0] a, input logic [31:0] b,
                                   input logic sgn);
      return (sgn && (a[31] ^ b[31])) ? 34 : 32;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkResetState(input string name);
      checkOutput({name, ".ctrl"}, 64'({Busy, Done, ALUReq, ALUControl}), 64'd0);
      checkOutput({name, ".src"}, {SrcA, SrcB}, 64'd0);
      checkOutput({name, ".hilo"}, {Hi, Lo}, 64'd0);
   endtask

   // mode 0: grant tied high; 1: random grant; 2: 10-cycle stall in MUL plus
   // one in NEGLO; 3: grant high, extra Start pulses mid-run and in DONE.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic sgn, input logic [63:0] expProd,
                                input int needSteps, input int mode,
                                input string name);
      int   steps = 0;
      int   cycles = 0;
      logic inOk = 1'b1;
      logic g;
      @(negedge Clk);
      Start = 1'b1; Signed = sgn; MultA = a; MultB = b;
      @(negedge Clk);
      Start = 1'b0; MultA = $urandom; MultB = $urandom; Signed = 1'($urandom_range(0, 1));
      while (steps < needSteps && cycles < 300) begin
         case (mode)
            1:       g = ($urandom_range(0, 3) != 0);
            2:       g = !((cycles >= 5 && cycles < 15) || cycles == 42);
            default: g = 1'b1;
         endcase
         ALUGrant = g;
         if (mode == 3) begin
            Start = (cycles == 10);
            if (cycles == 10) begin
               MultA = 32'h0000_0009; MultB = 32'h0000_0009; Signed = 1'b0;
            end
         end
         #1;
         if (!(Busy === 1'b1 && ALUReq === 1'b1 && Done === 1'b0 &&
               ALUControl === 3'b010)) inOk = 1'b0;
         @(posedge Clk);
         if (g) steps++;
         cycles++;
         @(negedge Clk);
      end
      Start = 1'b0;
      if (cycles >= 300) checkOutput({name, ".timeout"}, 64'(cycles), 64'd0);
      checkOutput({name, ".inmul"}, 64'(inOk), 64'd1);
      checkOutput({name, ".done"}, 64'(Done), 64'd1);
      checkOutput({name, ".busy"}, 64'(Busy), 64'd1);
      checkOutput({name, ".req"}, 64'(ALUReq), 64'd0);
      checkOutput({name, ".prod"}, {Hi, Lo}, expProd);
      ALUGrant = 1'($urandom_range(0, 1));
      if (mode == 3) begin
         Start = 1'b1; MultA = 32'd5; MultB = 32'd5; Signed = 1'b0;
      end
      @(negedge Clk);
      Start = 1'b0;
      ALUGrant = 1'b1;
      checkOutput({name, ".idle"}, 64'({Busy, Done, ALUReq}), 64'd0);
      checkOutput({name, ".hold"}, {Hi, Lo}, expProd);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected to end earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      logic        sawDone;

      vecs[0] = '{32'd3,         32'd5,         1'b0, 64'h00000000_0000000F, 32, 0};
      vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 64'hFFFFFFFE_00000001, 32, 0};
      vecs[2] = '{32'hFFFFFFFD,  32'd5,         1'b1, 64'hFFFFFFFF_FFFFFFF1, 34, 0};
      vecs[3] = '{32'h80000000,  32'h80000000,  1'b1, 64'h40000000_00000000, 32, 0};
      vecs[4] = '{32'd7,         32'hFFFFFFFF,  1'b1, 64'hFFFFFFFF_FFFFFFF9, 34, 2};
      vecs[5] = '{32'h00001234,  32'h00000100,  1'b0, 64'h00000000_00123400, 32, 3};
      vecs[6] = '{32'd0,         32'hFFFFFFFF,  1'b1, 64'h00000000_00000000, 34, 0};
      vecs[7] = '{32'd0,         32'd0,         1'b0, 64'h00000000_00000000, 32, 0};

      Reset_n = 1'b0; Start = 1'b0; Signed = 1'b0; MultA = '0; MultB = '0;
      ALUGrant = 1'b1;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      checkResetState("reset");

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].prod,
                       vecs[i].steps, vecs[i].mode, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 0) ra = 32'h80000000;
         rs = 1'($urandom_range(0, 1));
         applyStimulus(ra, rb, rs, refProduct(ra, rb, rs), refSteps(ra, rb, rs),
                       1, $sformatf("rand%0d", i));
      end

      // Reset in the middle of a multiply must abandon it without a Done pulse.
      @(negedge Clk);
      Start = 1'b1; Signed = 1'b0; MultA = 32'h12345678; MultB = 32'h9ABCDEF0;
      @(negedge Clk);
      Start = 1'b0;
      repeat (20) @(negedge Clk);
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      checkResetState("midreset");
      sawDone = 1'b0;
      repeat (40) begin
         @(negedge Clk);
         if (Done !== 1'b0 || Busy !== 1'b0) sawDone = 1'b1;
      end
      checkOutput("midreset.quiet", 64'(sawDone), 64'd0);
      applyStimulus(32'd2, 32'd2, 1'b0, 64'd4, 32, 0, "afterreset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
